// File: rtl/clk_switch_ctrl.sv
// Sequencer for the glitch-free link/core clock mux: drains traffic, gates the clock, flips the select and re-enables.
// Optional drain timeout with error pulse is compiled in with CLK_SW_TIMEOUT_EN.
module clk_switch_ctrl #(
  parameter int unsigned GATE_CYC    = 4,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run_en,
  input  logic sw_req,
  input  logic sw_dir,
  input  logic xfer_busy,
  output logic direct_back_path,
  output logic clk_enable,
  output logic sw_ack,
  output logic sw_err,
  output logic ctrl_busy
);

  typedef enum logic [2:0] {
    ST_START,
    ST_IDLE,
    ST_DRAIN,
    ST_GATE,
    ST_SWITCH,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  // Reject parameter sets the counter cannot represent or that would make a timed state zero-length.
  if (GATE_CYC < 1 || SETTLE_CYC < 1 || TIMEOUT_CYC < 1 ||
      longint'(GATE_CYC) > (longint'(1) << CNT_W) ||
      longint'(SETTLE_CYC) > (longint'(1) << CNT_W) ||
      longint'(TIMEOUT_CYC) > (longint'(1) << CNT_W)) begin : g_param_check
    $error("clk_switch_ctrl: cycle parameters out of range for CNT_W");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             dbp_q, dbp_d;
  logic             en_q, en_d;
  logic             ack_q, ack_d;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_dec;

`ifdef CLK_SW_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);
  logic err_q, err_d;
`endif

  assign cnt_zero = (cnt_q == '0);
  assign cnt_dec  = cnt_q - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    dbp_d   = dbp_q;
    en_d    = en_q;
    ack_d   = ack_q;
`ifdef CLK_SW_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_START: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_IDLE: begin
        if (sw_req) begin
          dir_d = sw_dir;
          // Already on the requested path: acknowledge without touching the clock.
          if (sw_dir == dbp_q) begin
            state_d = ST_DONE;
            ack_d   = 1'b1;
          end else begin
            state_d = ST_DRAIN;
`ifdef CLK_SW_TIMEOUT_EN
            cnt_d   = TIMEOUT_LD;
`endif
          end
        end
      end
      ST_DRAIN: begin
        if (!xfer_busy) begin
          state_d = ST_GATE;
          en_d    = 1'b0;
          cnt_d   = GATE_LD;
        end
`ifdef CLK_SW_TIMEOUT_EN
        else if (cnt_zero) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
`endif
      end
      ST_GATE: begin
        if (cnt_zero) begin
          state_d = ST_SWITCH;
          dbp_d   = dir_q;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_SWITCH: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
          en_d    = 1'b1;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_DONE: begin
        if (!sw_req) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_START;
        cnt_d   = SETTLE_LD;
        en_d    = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_START;
      cnt_q   <= SETTLE_LD;
      dir_q   <= 1'b0;
      dbp_q   <= 1'b0;
      en_q    <= 1'b0;
      ack_q   <= 1'b0;
`ifdef CLK_SW_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      dbp_q   <= dbp_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
`ifdef CLK_SW_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  // run_en only masks the mux enable; the sequence itself keeps running.
  assign clk_enable       = en_q & run_en;
  assign direct_back_path = dbp_q;
  assign sw_ack           = ack_q;
  assign ctrl_busy        = (state_q != ST_IDLE);
`ifdef CLK_SW_TIMEOUT_EN
  assign sw_err           = err_q;
`else
  assign sw_err           = 1'b0;
`endif

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: directed vector table, hand-written switch sequences and a randomized run
// against a timestamp-based reference model.
module tb_clk_switch_ctrl;

  localparam int GATE   = 4;
  localparam int SETTLE = 8;
  localparam int TMO    = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run_en = 1'b1;
  logic sw_req = 1'b0;
  logic sw_dir = 1'b0;
  logic xfer_busy = 1'b0;
  logic direct_back_path, clk_enable, sw_ack, sw_err, ctrl_busy;

  int checks = 0;
  int errors = 0;

  clk_switch_ctrl #(
    .GATE_CYC(GATE), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .sw_req(sw_req), .sw_dir(sw_dir),
    .xfer_busy(xfer_busy), .direct_back_path(direct_back_path), .clk_enable(clk_enable),
    .sw_ack(sw_ack), .sw_err(sw_err), .ctrl_busy(ctrl_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Output vector order: {direct_back_path, clk_enable, sw_ack, sw_err, ctrl_busy}
  function automatic logic [4:0] outv();
    return {direct_back_path, clk_enable, sw_ack, sw_err, ctrl_busy};
  endfunction

  task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got {dbp,en,ack,err,busy}=%b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks edge count since reset and schedules events as absolute edge numbers.
  int   m_n;
  int   m_phase;     // 0 idle, 1 waiting for drain, 2 switch scheduled, 3 acknowledged
  int   m_t_enter, m_t_flip, m_t_done;
  logic m_path, m_en, m_ack, m_err, m_tgt;

  function automatic void model_reset();
    m_n = 0; m_phase = 0; m_path = 1'b0; m_en = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_tgt = 1'b0;
    m_t_enter = 0; m_t_flip = 0; m_t_done = 0;
  endfunction

  function automatic void model_edge(input logic req, input logic dir, input logic busy);
    m_n++;
    m_err = 1'b0;
    if (m_n < SETTLE) return;
    if (m_n == SETTLE) begin
      m_en = 1'b1;
      return;
    end
    case (m_phase)
      0: if (req) begin
        m_tgt = dir;
        if (dir == m_path) begin
          m_ack = 1'b1; m_phase = 3;
        end else begin
          m_phase = 1; m_t_enter = m_n;
        end
      end
      1: begin
        if (!busy) begin
          m_en = 1'b0;
          m_t_flip = m_n + GATE;
          m_t_done = m_t_flip + SETTLE;
          m_phase = 2;
        end
`ifdef CLK_SW_TIMEOUT_EN
        else if (m_n - m_t_enter >= TMO) begin
          m_err = 1'b1; m_ack = 1'b1; m_phase = 3;
        end
`endif
      end
      2: begin
        if (m_n == m_t_flip) m_path = m_tgt;
        if (m_n == m_t_done) begin
          m_en = 1'b1; m_ack = 1'b1; m_phase = 3;
        end
      end
      default: if (!req) begin
        m_ack = 1'b0; m_phase = 0;
      end
    endcase
  endfunction

  function automatic logic [4:0] model_vec();
    logic cb;
    cb = (m_n < SETTLE) || (m_phase != 0);
    return {m_path, m_en & run_en, m_ack, m_err, cb};
  endfunction

  // Full switch to tgt with xfer_busy held d extra cycles; sw_dir is flipped mid-sequence and must be ignored.
  task automatic do_switch(input logic tgt, input int d);
    logic [4:0] exp;
    logic e_dbp, e_en, e_ack;
    sw_req = 1'b1; sw_dir = tgt; xfer_busy = (d > 0);
    for (int k = 1; k <= 14 + d; k++) begin
      tick();
      xfer_busy = (k <= d);
      if (k == 1) sw_dir = ~tgt;
      e_dbp = (k >= 6 + d) ? tgt : ~tgt;
      e_en  = !(k >= 2 + d && k <= 13 + d);
      e_ack = (k >= 14 + d);
      exp = {e_dbp, e_en, e_ack, 1'b0, 1'b1};
      chk($sformatf("switch_to%0b_d%0d_edge%0d", tgt, d, k), outv(), exp);
    end
    sw_req = 1'b0;
    tick();
    exp = {tgt, 1'b1, 1'b0, 1'b0, 1'b0};
    chk($sformatf("switch_to%0b_ack_drop", tgt), outv(), exp);
  endtask

  typedef struct {
    logic       req, dir, busy, run;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [4:0] exp;
    bit got_ack;

    for (int i = 0; i < 7; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00001};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b01000};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b01101};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 5'b01101};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b01000};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00101};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'b01000};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'b01000};

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_state", outv(), 5'b00001);
    reset = 1'b0;

    // Startup and no-op requests on the link path
    for (int i = 0; i < 15; i++) begin
      sw_req = tbl[i].req; sw_dir = tbl[i].dir; xfer_busy = tbl[i].busy; run_en = tbl[i].run;
      tick();
      chk($sformatf("table_edge%0d", i + 1), outv(), tbl[i].exp);
    end
    sw_req = 1'b0; sw_dir = 1'b0; xfer_busy = 1'b0; run_en = 1'b1;

    do_switch(1'b1, 0);
    do_switch(1'b0, 10);

    // Reset pulse while in SWITCH on a 0->1 switch
    sw_req = 1'b1; sw_dir = 1'b1;
    repeat (8) tick();
    chk("pre_reset_in_switch", outv(), 5'b10001);
    reset = 1'b1;
    #1;
    chk("async_reset_in_switch", outv(), 5'b00001);
    sw_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 1; k <= SETTLE; k++) begin
      tick();
      exp = (k < SETTLE) ? 5'b00001 : 5'b01000;
      chk($sformatf("restart_edge%0d", k), outv(), exp);
    end
    do_switch(1'b1, 0);

    // Drain with xfer_busy stuck high (path is now 1, request 0)
    sw_req = 1'b1; sw_dir = 1'b0; xfer_busy = 1'b1;
`ifdef CLK_SW_TIMEOUT_EN
    for (int k = 1; k <= 18; k++) begin
      tick();
      exp = {1'b1, 1'b1, (k >= 17), (k == 17), 1'b1};
      chk($sformatf("timeout_edge%0d", k), outv(), exp);
    end
    sw_req = 1'b0; xfer_busy = 1'b0;
    tick();
    chk("timeout_release", outv(), 5'b11000);
`else
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("drain_hold_edge%0d", k), outv(), 5'b11001);
    end
    xfer_busy = 1'b0;
    got_ack = 1'b0;
    for (int k = 0; k < 40 && !got_ack; k++) begin
      tick();
      got_ack = sw_ack;
    end
    checks++;
    if (!got_ack) begin
      errors++;
      $display("FAIL drain_release_ack: no sw_ack within 40 cycles");
    end
    chk("drain_release_done", outv(), 5'b01101);
    sw_req = 1'b0;
    tick();
    chk("drain_release_idle", outv(), 5'b01000);
`endif

    // Randomized run against the reference model
    reset = 1'b1; sw_req = 1'b0; xfer_busy = 1'b0; run_en = 1'b1;
    tick();
    tick();
    model_reset();
    reset = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        chk($sformatf("rand_async_reset_it%0d", it), outv(), model_vec());
        sw_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
      end
      run_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) xfer_busy = ~xfer_busy;
      if (!sw_req) begin
        if ($urandom_range(0, 4) == 0) begin
          sw_req = 1'b1;
          sw_dir = 1'($urandom_range(0, 1));
        end
      end else if (sw_ack) begin
        if ($urandom_range(0, 2) == 0) sw_req = 1'b0;
      end else begin
        if ($urandom_range(0, 149) == 0) sw_req = 1'b0;
        if ($urandom_range(0, 3) == 0) sw_dir = ~sw_dir;
      end
      model_edge(sw_req, sw_dir, xfer_busy);
      tick();
      chk($sformatf("rand_it%0d", it), outv(), model_vec());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Sequencer in the interface unit that sits directly upstream of the glitch-free link/core clock mux.
- Owns the mux's path-select (`direct_back_path`) and gate-enable (`clk_enable`) signals.
- Accepts direction-change requests from the interface controller over a 4-phase handshake.
- Performs each switch safely: drain in-flight transfers, gate the clock off, flip the select, wait for the mux synchronisers to settle, re-enable, acknowledge.

Parameters:
- GATE_CYC, 4, cycles `clk_enable` is held low before the select flips (must be ≥1).
- SETTLE_CYC, 8, cycles after the select flips before re-enable; covers 2 negedges of the slower mux clock (must be ≥1).
- TIMEOUT_CYC, 1024, drain timeout in cycles; used only with CLK_SW_TIMEOUT_EN.
- CNT_W, 16, counter width; must hold max(GATE_CYC, SETTLE_CYC, TIMEOUT_CYC).

Ports:
- clk  input  1  free-running control clock (core_clk domain).
- reset  input  1  reset, asynchronous, active-high.
- run_en  input  1  global output-clock enable; when 0, `clk_enable` is forced 0.
- sw_req  input  1  switch request; level, held until `sw_ack`.
- sw_dir  input  1  requested path: 0 = link clock, 1 = core clock (back path).
- xfer_busy  input  1  datapath transfer in flight; switching is blocked while 1.
- direct_back_path  output  1  select to the clock mux.
- clk_enable  output  1  enable to the clock mux.
- sw_ack  output  1  request complete; held until `sw_req` falls.
- sw_err  output  1  one-cycle pulse on drain timeout.
- ctrl_busy  output  1  high in any state except IDLE.

Behaviour:
- All outputs are registered except `clk_enable` and `ctrl_busy`.
- `clk_enable` = `en_r & run_en`.
- Reset values:
  - `direct_back_path`=0, `en_r`=0 (so `clk_enable`=0), `sw_ack`=0, `sw_err`=0.
  - state=START, counter=SETTLE_CYC-1.
- States: START, IDLE, DRAIN, GATE, SWITCH, DONE.
- The counter loads N-1 on entry to a timed state and decrements each cycle; the state exits on the edge where counter==0.
- START:
  - Counts SETTLE_CYC cycles, then goes to IDLE.
  - `en_r` is set on entry to IDLE, so the first enable comes SETTLE_CYC cycles after reset release.
- IDLE:
  - Samples `sw_dir` into a direction register when `sw_req`=1.
  - `sw_dir`==`direct_back_path` → DONE next edge (no gating, `en_r` unchanged).
  - Otherwise → DRAIN.
- DRAIN:
  - Stays while `xfer_busy`=1.
  - When `xfer_busy`=0 → GATE: `en_r` cleared on entry, counter=GATE_CYC-1.
- GATE: on exit → SWITCH; `direct_back_path` loads the latched direction on entry; counter=SETTLE_CYC-1.
- SWITCH: on exit → DONE; `en_r` set on entry, `sw_ack` set on entry.
- DONE:
  - `sw_ack` held 1.
  - When `sw_req`=0 → IDLE and `sw_ack` cleared.
  - `sw_dir` changes during DRAIN through DONE are ignored.
- Latency with defaults, `xfer_busy`=0, request accepted at edge 0:
  - Edge 1: DRAIN.
  - Edge 2: GATE; `clk_enable` falls.
  - Edge 6: SWITCH; select flips.
  - Edge 14: DONE; `clk_enable` rises and `sw_ack`=1.
- `run_en`:
  - Gates only the output.
  - It does not stall the FSM.
  - `run_en`=0 during a switch still completes the sequence.
- `xfer_busy` rising after DRAIN has been left is ignored.
- Reset asserted mid-operation:
  - Immediately returns to reset values; `clk_enable` drops asynchronously.
  - `direct_back_path` returns to 0 (link).
  - An in-progress request is dropped with no ack; the requester must re-request.
- `sw_req` deasserted before ack: protocol violation. The FSM completes the sequence and passes through DONE to IDLE on the next edge.

Optional Feature:
- Macro: CLK_SW_TIMEOUT_EN.
- Defined:
  - DRAIN loads counter=TIMEOUT_CYC-1 on entry.
  - If the counter reaches 0 with `xfer_busy`=1, the FSM goes to DONE without gating or switching.
  - In that case `sw_err` pulses for 1 cycle alongside the DONE entry, and `sw_ack` is asserted normally.
  - The requester checks `direct_back_path` or `sw_err` to see the switch failed.
- Undefined:
  - DRAIN waits indefinitely.
  - `sw_err` is tied to 0 and no timeout counter logic exists.

Test Plan:
- Reset release with `run_en`=1 → `clk_enable`=0 for 8 cycles, then 1. `direct_back_path`=0 throughout, `sw_ack`=0, `ctrl_busy`=1 in START and 0 afterwards.
- `sw_req`=1, `sw_dir`=0 while on the link path → `sw_ack`=1 one cycle after acceptance. `clk_enable` never drops. Dropping `sw_req` → `sw_ack`=0 next cycle.
- `sw_req`=1, `sw_dir`=1, `xfer_busy`=0, accepted at edge 0 → `clk_enable` low on edges 2–13, `direct_back_path`=1 from edge 6, `sw_ack`=1 and `clk_enable`=1 at edge 14.
- Same request with `xfer_busy`=1 for 10 cycles after acceptance → every event is delayed by 10 cycles versus the previous case. `clk_enable` stays 1 while DRAIN waits.
- Reset pulse during SWITCH on a 0→1 switch → `direct_back_path`=0 and `clk_enable`=0 immediately, no `sw_ack`. A fresh request afterwards completes normally.
- With CLK_SW_TIMEOUT_EN and TIMEOUT_CYC=16, `xfer_busy` held 1 → `sw_err` pulses for 1 cycle and `sw_ack`=1 at edge 17. `direct_back_path` is unchanged and `clk_enable` never drops.
